cond_flag_unit: RTL and testbench
=================================

# cond_flag_unit

Execute-stage condition unit that sits directly downstream of the ALU flag generator. It holds the architectural NZCV status register, evaluates the 4-bit instruction condition field against it, and forwards condition-gated control signals (PCS, RegWrite, MemWrite) into a registered execute-to-memory boundary. All flag state updates are qualified by the instruction's validity, its own condition outcome and the pipeline stall/flush controls.

## Interface
- INIT_FLAGS, 4'b0000, reset value of the status register {N,Z,C,V}
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- ValidE  input  1  execute-stage instruction valid
- StallE  input  1  execute stage held this cycle
- FlushE  input  1  execute-stage instruction squashed this cycle
- Cond  input  4  instruction condition field
- FlagWriteE  input  2  [1] updates N,Z; [0] updates C,V
- ALUFlags  input  4  {N,Z,C,V} from the flag generator
- PCSE, RegWriteE, MemWriteE  input  1 each  ungated execute controls
- ClearSticky  input  1  clears sticky overflow (macro build only)
- CondExE  output  1  combinational condition result for the current instruction
- Flags  output  4  current status register {N,Z,C,V}
- ValidM, PCSrcM, RegWriteM, MemWriteM  output  1 each  registered gated controls
- StickyV  output  1  sticky overflow (tied 0 without macro)

## Operation
- Condition decode on Flags register (never on ALUFlags): 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 reserved → 0.
- Commit = ValidE & ~StallE & ~FlushE & CondExE.
- Flag update on commit: FlagWriteE[1] loads N,Z from ALUFlags[3:2]; FlagWriteE[0] loads C,V from ALUFlags[1:0]; unselected bits hold. FlagWriteE=00 never changes Flags.
- Boundary register: if ValidE & ~StallE & ~FlushE, ValidM←1 and each control ←its E input & CondExE; otherwise all four ← 0 (bubble).
- Failed condition: ValidM←1 with all gated controls 0; no flag update.
- Flush has priority over stall; both block flag update.

## Timing
- CondExE: combinational, same cycle as Cond/Flags.
- Flags: updated at the rising edge of the commit cycle; visible to the next instruction's CondExE one cycle later (back-to-back dependent instructions need no bypass).
- Gated controls: latency 1 cycle.
- Reset (async, any time, including mid-stall): Flags←INIT_FLAGS, ValidM/PCSrcM/RegWriteM/MemWriteM←0, StickyV←0; outputs change without a clock edge.
- Deassertion of rst takes effect on the next rising edge; first commit possible that edge.

## Configuration
- STICKY_OVF_EN defined: StickyV sets on any commit with FlagWriteE[0]=1 and ALUFlags[0]=1; stays set until ClearSticky=1 or rst. Same-cycle set and ClearSticky: set wins.
- Undefined: no sticky register; StickyV tied 0; ClearSticky ignored.

## Test plan
- Reset: INIT_FLAGS=4'b0100, assert rst mid-cycle → Flags=0100, all M outputs 0 immediately; Cond=0000 then gives CondExE=1.
- Flag write masks: Flags=0000, ALUFlags=1111, FlagWriteE=10, commit → Flags=1100; next FlagWriteE=01 ALUFlags=0000 → Flags=1100 unchanged for N,Z, C,V=00.
- Full condition sweep: for each Flags value 0000–1111, Cond 0000–1111 → CondExE matches decode list; Cond=1111 always 0.
- Condition fail: Flags Z=0, Cond=EQ, RegWriteE=MemWriteE=1, FlagWriteE=11 → next cycle ValidM=1, RegWriteM=MemWriteM=0, Flags unchanged.
- Stall/flush: StallE=1 with AL and FlagWriteE=11, ALUFlags=1010 → Flags unchanged, ValidM=0; StallE=FlushE=1 → same; release → Flags=1010 after one edge.
- Sticky (macro): commit with FlagWriteE=01, ALUFlags=0001 → StickyV=1; later V=0 commits keep 1; ClearSticky with simultaneous V=1 commit → StickyV stays 1; ClearSticky alone → 0.

Source files
------------

// File: rtl/cond_flag_unit.sv
// Execute-stage condition unit: NZCV status register, condition decode and gated E->M boundary register.
// Optional build macro STICKY_OVF_EN adds a sticky overflow flag cleared by ClearSticky.
module cond_flag_unit #(
  parameter logic [3:0] INIT_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ValidE,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic [3:0] Cond,
  input  logic [1:0] FlagWriteE,
  input  logic [3:0] ALUFlags,
  input  logic       PCSE,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       ClearSticky,
  output logic       CondExE,
  output logic [3:0] Flags,
  output logic       ValidM,
  output logic       PCSrcM,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       StickyV
);

  logic [3:0] flags_reg, flags_next;
  logic       valid_m_reg, pcs_m_reg, reg_write_m_reg, mem_write_m_reg;
  logic       cond_ex;
  logic       issue, commit;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_reg;

  // Decode always reads the architectural register, never the incoming ALU flags.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign issue  = ValidE & ~StallE & ~FlushE;
  assign commit = issue & cond_ex;

  // Field gi=1 is {N,Z}, gi=0 is {C,V}; each pair has its own write enable.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag_field
      assign flags_next[2*gi+1 -: 2] = (commit & FlagWriteE[gi]) ? ALUFlags[2*gi+1 -: 2]
                                                                 : flags_reg[2*gi+1 -: 2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_reg       <= INIT_FLAGS;
      valid_m_reg     <= 1'b0;
      pcs_m_reg       <= 1'b0;
      reg_write_m_reg <= 1'b0;
      mem_write_m_reg <= 1'b0;
    end else begin
      flags_reg       <= flags_next;
      valid_m_reg     <= issue;
      pcs_m_reg       <= issue & PCSE & cond_ex;
      reg_write_m_reg <= issue & RegWriteE & cond_ex;
      mem_write_m_reg <= issue & MemWriteE & cond_ex;
    end
  end

`ifdef STICKY_OVF_EN
  logic sticky_reg;
  logic sticky_set;

  assign sticky_set = commit & FlagWriteE[0] & ALUFlags[0];

  // A new overflow in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_reg <= 1'b0;
    end else if (sticky_set) begin
      sticky_reg <= 1'b1;
    end else if (ClearSticky) begin
      sticky_reg <= 1'b0;
    end
  end

  assign StickyV = sticky_reg;
`else
  logic unused_clear_sticky;
  assign unused_clear_sticky = ClearSticky;
  assign StickyV = 1'b0;
`endif

  assign CondExE   = cond_ex;
  assign Flags     = flags_reg;
  assign ValidM    = valid_m_reg;
  assign PCSrcM    = pcs_m_reg;
  assign RegWriteM = reg_write_m_reg;
  assign MemWriteM = mem_write_m_reg;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: expected boundary/flag state queued at drive time, compared after the edge.
module tb_cond_flag_unit;

  localparam logic [3:0] INIT = 4'b0100;

  logic       clk = 1'b0;
  logic       rst;
  logic       ValidE, StallE, FlushE;
  logic [3:0] Cond;
  logic [1:0] FlagWriteE;
  logic [3:0] ALUFlags;
  logic       PCSE, RegWriteE, MemWriteE, ClearSticky;
  logic       CondExE;
  logic [3:0] Flags;
  logic       ValidM, PCSrcM, RegWriteM, MemWriteM, StickyV;

  cond_flag_unit #(.INIT_FLAGS(INIT)) dut (
    .clk(clk), .rst(rst), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
    .Cond(Cond), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
    .PCSE(PCSE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ClearSticky(ClearSticky), .CondExE(CondExE), .Flags(Flags),
    .ValidM(ValidM), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .StickyV(StickyV)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       validm, pcs, rw, mw;
    logic [3:0] flags;
    logic       sticky;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] model_flags;
  logic       model_sticky;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Pairs of conditions share a base test; odd codes invert it, 1111 is never true.
  function automatic logic exp_cond(input logic [3:0] f, input logic [3:0] cc);
    logic fn, fz, fc, fv, r;
    {fn, fz, fc, fv} = f;
    case (cc[3:1])
      3'd0: r = fz;
      3'd1: r = fc;
      3'd2: r = fn;
      3'd3: r = fv;
      3'd4: r = fc & ~fz;
      3'd5: r = (fn == fv);
      3'd6: r = ~fz & (fn == fv);
      default: r = 1'b1;
    endcase
    if (cc == 4'hF) r = 1'b0;
    else if (cc[0]) r = ~r;
    return r;
  endfunction

  task automatic apply(input logic vld, input logic stl, input logic fls, input logic [3:0] cc,
                       input logic [1:0] fw, input logic [3:0] alu,
                       input logic pcs, input logic rw, input logic mw, input logic clr);
    logic ce, iss, com, set;
    exp_t e, got;
    ValidE = vld; StallE = stl; FlushE = fls; Cond = cc; FlagWriteE = fw; ALUFlags = alu;
    PCSE = pcs; RegWriteE = rw; MemWriteE = mw; ClearSticky = clr;
    #1;
    ce  = exp_cond(model_flags, cc);
    check($sformatf("condex f=%b c=%b", model_flags, cc), {7'd0, CondExE}, {7'd0, ce});
    iss = vld & ~stl & ~fls;
    com = iss & ce;
    if (com & fw[1]) model_flags[3:2] = alu[3:2];
    if (com & fw[0]) model_flags[1:0] = alu[1:0];
`ifdef STICKY_OVF_EN
    set = com & fw[0] & alu[0];
    if (set) model_sticky = 1'b1;
    else if (clr) model_sticky = 1'b0;
`else
    set = 1'b0;
    model_sticky = set;
`endif
    e.validm = iss; e.pcs = iss & ce & pcs; e.rw = iss & ce & rw; e.mw = iss & ce & mw;
    e.flags = model_flags; e.sticky = model_sticky;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 8'd0, 8'd1);
    end else begin
      e = sb.pop_front();
      got = '{ValidM, PCSrcM, RegWriteM, MemWriteM, Flags, StickyV};
      check("ctrl_m", {4'd0, got.validm, got.pcs, got.rw, got.mw}, {4'd0, e.validm, e.pcs, e.rw, e.mw});
      check("flags", {4'd0, got.flags}, {4'd0, e.flags});
      check("sticky", {7'd0, got.sticky}, {7'd0, e.sticky});
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_flags"}, {4'd0, Flags}, {4'd0, INIT});
    check({tag, "_ctrl"}, {3'd0, ValidM, PCSrcM, RegWriteM, MemWriteM, StickyV}, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ValidE = 0; StallE = 0; FlushE = 0; Cond = 0; FlagWriteE = 0; ALUFlags = 0;
    PCSE = 0; RegWriteE = 0; MemWriteE = 0; ClearSticky = 0;
    model_flags = INIT; model_sticky = 1'b0;
    #3;
    check_reset_state("reset_initial");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset value Z=1 makes EQ true
    apply(1, 0, 0, 4'b0000, 2'b00, 4'b1111, 1, 1, 1, 0);

    // Flag write masks
    apply(1, 0, 0, 4'b1110, 2'b11, 4'b0000, 0, 1, 0, 0);
    apply(1, 0, 0, 4'b1110, 2'b10, 4'b1111, 0, 1, 0, 0);
    apply(1, 0, 0, 4'b1110, 2'b01, 4'b0000, 0, 1, 0, 0);
    apply(1, 0, 0, 4'b1110, 2'b00, 4'b0011, 1, 0, 1, 0);

    // Condition fail: Z=0, EQ
    apply(1, 0, 0, 4'b1110, 2'b11, 4'b0000, 0, 0, 0, 0);
    apply(1, 0, 0, 4'b0000, 2'b11, 4'b1111, 1, 1, 1, 0);
    apply(1, 0, 0, 4'b1111, 2'b11, 4'b1111, 1, 1, 1, 0);

    // Stall, stall+flush, flush, invalid, then release
    apply(1, 1, 0, 4'b1110, 2'b11, 4'b1010, 1, 1, 1, 0);
    apply(1, 1, 1, 4'b1110, 2'b11, 4'b1010, 1, 1, 1, 0);
    apply(1, 0, 1, 4'b1110, 2'b11, 4'b1010, 1, 1, 1, 0);
    apply(0, 0, 0, 4'b1110, 2'b11, 4'b1010, 1, 1, 1, 0);
    apply(1, 0, 0, 4'b1110, 2'b11, 4'b1010, 1, 1, 1, 0);

    // Full condition sweep
    for (int f = 0; f < 16; f++) begin
      apply(1, 0, 0, 4'b1110, 2'b11, 4'(f), 0, 0, 0, 0);
      for (int cc = 0; cc < 16; cc++)
        apply(0, 0, 0, 4'(cc), 2'b00, 4'b0000, 0, 0, 0, 0);
    end

    // Random mix
    for (int i = 0; i < 60; i++)
      apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
            4'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

`ifdef STICKY_OVF_EN
    apply(1, 0, 0, 4'b1110, 2'b01, 4'b0001, 0, 0, 0, 0);
    apply(1, 0, 0, 4'b1110, 2'b01, 4'b0000, 0, 0, 0, 0);
    apply(1, 0, 0, 4'b1110, 2'b11, 4'b0000, 0, 0, 0, 0);
    apply(1, 0, 0, 4'b1110, 2'b01, 4'b0001, 0, 0, 0, 1);
    apply(0, 0, 0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 1);
`endif

    // Async reset mid-stall with nonzero M outputs and non-init flags
    apply(1, 0, 0, 4'b1110, 2'b11, 4'b1010, 1, 1, 1, 0);
    StallE = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_reset_state("reset_midstall");
    model_flags = INIT; model_sticky = 1'b0;
    StallE = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    apply(1, 0, 0, 4'b0000, 2'b10, 4'b1000, 1, 0, 0, 0);
    apply(1, 0, 0, 4'b0100, 2'b00, 4'b0000, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
